// File: rtl/mem2sram16_pkg.sv
// mem2sram16_pkg: FSM state and read-tag types shared by the 32-to-16 bit SRAM bridge
package mem2sram16_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, RDWAIT} state_t;
    typedef struct packed {
        logic valid;
        logic half;
    } tag_t;
endpackage

// File: rtl/mem2sram16_if.sv
// mem2sram16_if: 32-bit memory request port between the AXI bridge and the SRAM controller
interface mem2sram16_if;
    logic        s_cs;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_byte;
    logic [31:0] s_di;
    logic [31:0] s_do;
    logic        s_busy;
    modport master (output s_cs, s_we, s_addr, s_byte, s_di, input s_do, s_busy);
    modport slave (input s_cs, s_we, s_addr, s_byte, s_di, output s_do, s_busy);
endinterface

// File: rtl/mem2sram16_ctrl_rdpipe.sv
// sram_rdpipe: RD_LAT-deep {valid, half} tag delay aligning each issued read with its returned halfword
module sram_rdpipe
    import mem2sram16_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic aclk,
    input  logic aresetn,
    input  tag_t tag_in,
    output logic cap_valid,
    output logic cap_half
);
    tag_t sr [RD_LAT];
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            for (int i = 0; i < RD_LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
        end
    assign cap_valid = sr[RD_LAT-1].valid;
    assign cap_half  = sr[RD_LAT-1].half;
endmodule

// File: rtl/mem2sram16_ctrl.sv
// mem2sram16_ctrl: splits 32-bit memory accesses into low/high halfword cycles on a 16-bit synchronous SRAM
module mem2sram16_ctrl
    import mem2sram16_pkg::*;
#(
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    mem2sram16_if.slave      s,
    output logic             sram_ce,
    output logic             sram_we,
    output logic [AW-1:0]    sram_addr,
    output logic [1:0]       sram_bwe,
    output logic [15:0]      sram_di,
    input  logic [15:0]      sram_do
);
    state_t        state, nxt;
    logic          idle;
    logic          we_q, cur_we;
    logic [AW-2:0] addr_q, cur_addr;
    logic [3:0]    byte_q, cur_byte;
    logic [31:0]   di_q, cur_di;
    logic          ce_d, we_d, half;
    logic [AW-1:0] addr_d;
    logic [1:0]    bwe_d;
    logic [15:0]   di_d;
    logic          cap_valid, cap_half;
    tag_t          rd_tag;
    logic          unused_addr;

    assign idle        = state == IDLE;
    assign s.s_busy    = !idle;
    assign unused_addr = ^{s.s_addr[31:AW+1], s.s_addr[1:0]};
    // In IDLE the accept-edge SRAM cycle is built straight from the request, not the latches
    assign cur_we   = idle ? s.s_we : we_q;
    assign cur_addr = idle ? s.s_addr[AW:2] : addr_q;
    assign cur_byte = idle ? s.s_byte : byte_q;
    assign cur_di   = idle ? s.s_di : di_q;

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !s.s_cs ? IDLE : (!cur_we || |cur_byte[1:0]) ? LO : |cur_byte[3:2] ? HI : IDLE;
            LO:      nxt = (cur_we && !(|cur_byte[3:2])) ? IDLE : HI;
            HI:      nxt = cur_we ? IDLE : RDWAIT;
            default: nxt = (cap_valid && cap_half) ? IDLE : RDWAIT;
        endcase
    end

    always_comb begin
        ce_d   = nxt == LO || nxt == HI;
        half   = nxt == HI;
        we_d   = ce_d && cur_we;
        addr_d = ce_d ? {cur_addr, half} : '0;
        bwe_d  = we_d ? (half ? cur_byte[3:2] : cur_byte[1:0]) : 2'b00;
        di_d   = we_d ? (half ? cur_di[31:16] : cur_di[15:0]) : 16'h0000;
    end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            byte_q    <= '0;
            di_q      <= '0;
            sram_ce   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_bwe  <= '0;
            sram_di   <= '0;
            s.s_do    <= '0;
        end else begin
            if (idle) begin
                we_q   <= s.s_we;
                addr_q <= s.s_addr[AW:2];
                byte_q <= s.s_byte;
                di_q   <= s.s_di;
            end
            sram_ce   <= ce_d;
            sram_we   <= we_d;
            sram_addr <= addr_d;
            sram_bwe  <= bwe_d;
            sram_di   <= di_d;
            if (cap_valid && cap_half) s.s_do[31:16] <= sram_do;
            if (cap_valid && !cap_half) s.s_do[15:0] <= sram_do;
        end

    // Tag is taken from the registered SRAM outputs, so RD_LAT stages land on the data-valid cycle
    assign rd_tag = '{valid: sram_ce && !sram_we, half: sram_addr[0]};

    sram_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .tag_in    (rd_tag),
        .cap_valid (cap_valid),
        .cap_half  (cap_half)
    );
endmodule

// File: tb/tb_mem2sram16_ctrl.sv
// tb_mem2sram16_ctrl: directed bench for RD_LAT=1 and RD_LAT=3 instances sharing one SRAM model
module tb_mem2sram16_ctrl;
    typedef struct packed {
        logic        ce;
        logic        we;
        logic [15:0] a;
        logic [1:0]  bwe;
        logic [15:0] d;
    } cyc_t;
    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } out_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        sel, cs, we;
    logic [31:0] addr, di;
    logic [3:0]  bt;
    int n_chk = 0;
    int n_err = 0;
    cyc_t cq[$];
    out_t oq[$];
    cyc_t m_got, m_exp;
    out_t m_o;
    logic prev_busy = 1'b0;

    mem2sram16_if m1 ();
    mem2sram16_if m3 ();
    assign m1.s_cs = cs && !sel;
    assign m3.s_cs = cs && sel;
    assign m1.s_we = we;
    assign m3.s_we = we;
    assign m1.s_addr = addr;
    assign m3.s_addr = addr;
    assign m1.s_byte = bt;
    assign m3.s_byte = bt;
    assign m1.s_di = di;
    assign m3.s_di = di;

    logic        ce1, we1, ce3, we3;
    logic [15:0] sa1, sd1, sa3, sd3, sdo_in;
    logic [1:0]  sb1, sb3;

    mem2sram16_ctrl #(.AW(16), .RD_LAT(1)) u1 (
        .aclk(aclk), .aresetn(aresetn), .s(m1.slave), .sram_ce(ce1), .sram_we(we1),
        .sram_addr(sa1), .sram_bwe(sb1), .sram_di(sd1), .sram_do(sdo_in));
    mem2sram16_ctrl #(.AW(16), .RD_LAT(3)) u3 (
        .aclk(aclk), .aresetn(aresetn), .s(m3.slave), .sram_ce(ce3), .sram_we(we3),
        .sram_addr(sa3), .sram_bwe(sb3), .sram_di(sd3), .sram_do(sdo_in));

    logic        busy, mce, mwe;
    logic [15:0] ma, mdi;
    logic [1:0]  mbwe;
    logic [31:0] sdo;
    assign busy = sel ? m3.s_busy : m1.s_busy;
    assign sdo  = sel ? m3.s_do : m1.s_do;
    assign mce  = sel ? ce3 : ce1;
    assign mwe  = sel ? we3 : we1;
    assign ma   = sel ? sa3 : sa1;
    assign mbwe = sel ? sb3 : sb1;
    assign mdi  = sel ? sd3 : sd1;

    // Synchronous SRAM: read data appears RD_LAT cycles after its ce cycle
    logic [15:0] mem [65536];
    logic [15:0] rp [4];
    always @(posedge aclk) begin
        if (mce && mwe) begin
            if (mbwe[0]) mem[ma][7:0] = mdi[7:0];
            if (mbwe[1]) mem[ma][15:8] = mdi[15:8];
        end
        rp[0] <= (mce && !mwe) ? mem[ma] : 16'h0000;
        for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
    end
    assign sdo_in = sel ? rp[2] : rp[0];

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge aclk);
    endtask

    task automatic expc(input logic w, input logic [15:0] ad, input logic [1:0] b, input logic [15:0] d);
        cq.push_back(cyc_t'{1'b1, w, ad, b, d});
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        cs = 1'b1; we = w; addr = a; bt = b; di = d;
        step;
        cs = 1'b0;
    endtask

    task automatic expect_busy(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s_busy_c%0d", tag, i), 40'(busy), 40'd1);
            step;
        end
        chk({tag, "_idle"}, 40'(busy), 40'd0);
    endtask

    // Every SRAM cycle is matched against the expected-cycle queue; reads are checked when busy falls
    always @(negedge aclk) begin
        if (aresetn && mce) begin
            m_exp = cq.size() != 0 ? cq.pop_front() : cyc_t'(0);
            m_got = cyc_t'{1'b1, mwe, ma, mbwe, mwe ? mdi : 16'h0000};
            chk("sram_cycle", 40'(m_got), 40'(m_exp));
        end
        if (aresetn && prev_busy && !busy && oq.size() != 0) begin
            m_o = oq.pop_front();
            if (m_o.rd) chk("rd_data", 40'(sdo), 40'(m_o.data));
        end
        prev_busy = busy;
    end

    initial begin
        sel = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; bt = '0; di = '0;
        #3;
        chk("rst_busy1", 40'(m1.s_busy), 40'd0);
        chk("rst_do1", 40'(m1.s_do), 40'd0);
        chk("rst_sram1", 40'({ce1, we1, sa1, sb1, sd1}), 40'd0);
        chk("rst_busy3", 40'(m3.s_busy), 40'd0);
        chk("rst_do3", 40'(m3.s_do), 40'd0);
        chk("rst_sram3", 40'({ce3, we3, sa3, sb3, sd3}), 40'd0);
        step;
        #2 aresetn = 1'b1;
        step;
        // RD_LAT=1 read; byte strobes must not suppress read halves
        mem[16'h100] = 16'hBEEF; mem[16'h101] = 16'hDEAD;
        expc(1'b0, 16'h100, 2'b00, 16'h0); expc(1'b0, 16'h101, 2'b00, 16'h0);
        oq.push_back(out_t'{1'b1, 32'hDEADBEEF});
        issue(1'b0, 32'h200, 4'h0, 32'h0);
        chk("rd1_lo_addr", 40'({mce, ma}), 40'({1'b1, 16'h100}));
        step;
        chk("rd1_hi_addr", 40'({mce, ma}), 40'({1'b1, 16'h101}));
        step;
        chk("rd1_busy_c3", 40'(busy), 40'd1);
        step;
        chk("rd1_done", 40'({busy, sdo}), 40'({1'b0, 32'hDEADBEEF}));
        // full write
        expc(1'b1, 16'h8, 2'b11, 16'h5678); expc(1'b1, 16'h9, 2'b11, 16'h1234);
        oq.push_back(out_t'(0));
        issue(1'b1, 32'h10, 4'hF, 32'h12345678);
        expect_busy("wr_full", 2);
        chk("wr_full_mem", 40'({mem[16'h9], mem[16'h8]}), 40'h12345678);
        // high-half-only write touching one byte lane
        mem[16'h11] = 16'h5500;
        expc(1'b1, 16'h11, 2'b01, 16'hAABB);
        oq.push_back(out_t'(0));
        issue(1'b1, 32'h20, 4'h4, 32'hAABBCCDD);
        expect_busy("wr_hi", 1);
        chk("wr_hi_mem", 40'(mem[16'h11]), 40'h55BB);
        // low-half-only write
        expc(1'b1, 16'h18, 2'b11, 16'hFEDC);
        oq.push_back(out_t'(0));
        issue(1'b1, 32'h30, 4'h3, 32'h9876FEDC);
        expect_busy("wr_lo", 1);
        // empty strobe write: no SRAM cycle, never busy
        issue(1'b1, 32'h50, 4'h0, 32'hFFFFFFFF);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("wr_none_c%0d", i), 40'({busy, mce}), 40'd0);
            step;
        end
        // request during HI of a write is ignored
        expc(1'b1, 16'h20, 2'b11, 16'hF00D); expc(1'b1, 16'h21, 2'b11, 16'hCAFE);
        oq.push_back(out_t'(0));
        issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
        chk("csb_busy_c1", 40'(busy), 40'd1);
        step;
        cs = 1'b1; addr = 32'h80; di = 32'h0;
        chk("csb_busy_c2", 40'(busy), 40'd1);
        step;
        cs = 1'b0;
        chk("csb_idle_c3", 40'(busy), 40'd0);
        step;
        chk("csb_no_cycle_c4", 40'({busy, mce}), 40'd0);
        // RD_LAT=3 back-to-back reads
        sel = 1'b1;
        mem[16'h40] = 16'h1111; mem[16'h41] = 16'h2222;
        mem[16'h60] = 16'h3333; mem[16'h61] = 16'h4444;
        expc(1'b0, 16'h40, 2'b00, 16'h0); expc(1'b0, 16'h41, 2'b00, 16'h0);
        expc(1'b0, 16'h60, 2'b00, 16'h0); expc(1'b0, 16'h61, 2'b00, 16'h0);
        oq.push_back(out_t'{1'b1, 32'h22221111});
        oq.push_back(out_t'{1'b1, 32'h44443333});
        issue(1'b0, 32'h80, 4'h0, 32'h0);
        expect_busy("b2b_a", 5);
        chk("b2b_a_data", 40'(sdo), 40'h22221111);
        issue(1'b0, 32'hC0, 4'h0, 32'h0);
        chk("b2b_nogap", 40'({mce, ma}), 40'({1'b1, 16'h60}));
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("b2b_hold_c%0d", i), 40'({busy, sdo}), 40'({1'b1, 32'h22221111}));
            step;
        end
        chk("b2b_lo_first", 40'({busy, sdo}), 40'({1'b1, 32'h22223333}));
        step;
        chk("b2b_b_done", 40'({busy, sdo}), 40'({1'b0, 32'h44443333}));
        // reset while waiting for the high half
        mem[16'h70] = 16'h5555; mem[16'h71] = 16'h6666;
        expc(1'b0, 16'h70, 2'b00, 16'h0); expc(1'b0, 16'h71, 2'b00, 16'h0);
        oq.push_back(out_t'{1'b1, 32'h66665555});
        issue(1'b0, 32'hE0, 4'h0, 32'h0);
        step;
        step;
        chk("rst_mid_rdwait", 40'(busy), 40'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_busy_do", 40'({busy, sdo}), 40'd0);
        chk("rst_mid_sram", 40'({mce, mwe, ma, mbwe, mdi}), 40'd0);
        oq.delete();
        #1 aresetn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step;
            chk($sformatf("rst_no_capture_c%0d", i), 40'({busy, sdo}), 40'd0);
        end
        chk("rst_cq_drained", 40'(cq.size()), 40'd0);
        expc(1'b0, 16'h40, 2'b00, 16'h0); expc(1'b0, 16'h41, 2'b00, 16'h0);
        oq.push_back(out_t'{1'b1, 32'h22221111});
        issue(1'b0, 32'h80, 4'h0, 32'h0);
        expect_busy("post_rst", 5);
        chk("post_rst_data", 40'(sdo), 40'h22221111);
        step;
        chk("cq_empty", 40'(cq.size()), 40'd0);
        chk("oq_empty", 40'(oq.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
